// File: rtl/adc_serial_rx_if.sv
// Handshake/bus bundle between the serial-ADC front end and its user:
// frame requests in, ADC pins out, and the sample-buffer write port.
interface adc_serial_rx_if #(
   parameter int CH_W     = 2,
   parameter int OUT_BITS = 8
);
   logic                start;
   logic                cont_en;
   logic                adc_data;
   logic                adc_clk;
   logic                adc_conv;
   logic [CH_W-1:0]     adc_ch;
   logic                busy;
   logic                write_enable;
   logic [OUT_BITS-1:0] write_data;
   logic [CH_W-1:0]     write_ch;

   modport master (
      output start, cont_en, adc_data,
      input  adc_clk, adc_conv, adc_ch, busy, write_enable, write_data, write_ch
   );

   modport slave (
      input  start, cont_en, adc_data,
      output adc_clk, adc_conv, adc_ch, busy, write_enable, write_data, write_ch
   );
endinterface

// File: rtl/adc_serial_rx.sv
// Serial-ADC front end: divides osc_clk into the ADC bit clock, drives the
// active-low conversion strobe, shifts in an MSB-first result and posts the
// top OUT_BITS bits, tagged with the mux channel, as a one-cycle write.
module adc_serial_rx #(
   parameter int ADC_BITS    = 12,
   parameter int OUT_BITS    = 8,
   parameter int CLK_DIV     = 64,
   parameter int CONV_CYCLES = 2,
   parameter int NUM_CH      = 4
) (
   input logic             osc_clk,
   input logic             reset,
   adc_serial_rx_if.slave  bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int N     = CONV_CYCLES + ADC_BITS;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PER_W = $clog2(N + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [PER_W-1:0] CONV_LAST  = PER_W'(CONV_CYCLES - 1);
   localparam logic [PER_W-1:0] FRAME_LAST = PER_W'(N - 1);
   localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

   if (OUT_BITS > ADC_BITS || OUT_BITS < 1) begin : g_bad_out_bits
      $error("adc_serial_rx: OUT_BITS must be in 1..ADC_BITS");
   end
   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("adc_serial_rx: CLK_DIV must be >= 1");
   end
   if (CONV_CYCLES < 1) begin : g_bad_conv_cycles
      $error("adc_serial_rx: CONV_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_DONE} state_t;

   state_t              state_q,    state_d;
   logic [DIV_W-1:0]    div_q,      div_d;
   logic [PER_W-1:0]    per_q,      per_d;
   logic                adc_clk_q,  adc_clk_d;
   logic                adc_conv_q, adc_conv_d;
   logic [CH_W-1:0]     adc_ch_q,   adc_ch_d;
   logic [ADC_BITS-1:0] shreg_q,    shreg_d;
   logic                we_q,       we_d;
   logic [OUT_BITS-1:0] wd_q,       wd_d;
   logic [CH_W-1:0]     wc_q,       wc_d;

   // tick marks the last osc_clk cycle of an adc_clk half-period;
   // period_end is the last cycle of a whole (low+high) period.
   logic tick, period_end;
   assign tick       = (div_q == DIV_LAST);
   assign period_end = tick & adc_clk_q;

   // Next-state and next-output logic; every output is registered so the
   // ADC pins and the write port change only on osc_clk edges.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      per_d      = per_q;
      adc_clk_d  = adc_clk_q;
      adc_conv_d = adc_conv_q;
      adc_ch_d   = adc_ch_q;
      shreg_d    = shreg_q;
      we_d       = 1'b0;
      wd_d       = wd_q;
      wc_d       = wc_q;
      case (state_q)
         S_IDLE: begin
            adc_clk_d  = 1'b0;
            adc_conv_d = 1'b1;
            div_d      = '0;
            per_d      = '0;
            if (bus.start | bus.cont_en) begin
               state_d    = S_CONV;
               adc_conv_d = 1'b0;
            end
         end
         S_CONV, S_SHIFT: begin
            if (tick) begin
               div_d     = '0;
               adc_clk_d = ~adc_clk_q;
               if (adc_clk_q) begin
                  per_d = per_q + 1'b1;
               end else if (state_q == S_SHIFT) begin
                  // Bit taken on the rising adc_clk edge; first bit ends as MSB.
                  shreg_d = (shreg_q << 1) | ADC_BITS'(bus.adc_data);
               end
            end else begin
               div_d = div_q + 1'b1;
            end
            if (period_end && state_q == S_CONV && per_q == CONV_LAST) begin
               state_d    = S_SHIFT;
               adc_conv_d = 1'b1;
            end
            if (period_end && state_q == S_SHIFT && per_q == FRAME_LAST) begin
               state_d = S_DONE;
               we_d    = 1'b1;
               wd_d    = shreg_q[ADC_BITS-1 -: OUT_BITS];
               wc_d    = adc_ch_q;
            end
         end
         S_DONE: begin
            div_d     = '0;
            per_d     = '0;
            adc_clk_d = 1'b0;
            adc_ch_d  = (NUM_CH == 1 || adc_ch_q == CH_LAST) ? '0 : adc_ch_q + 1'b1;
            if (bus.cont_en) begin
               state_d    = S_CONV;
               adc_conv_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; the shift register is pure data and is never reset
   // because every frame overwrites all of its bits before they are used.
   always_ff @(posedge osc_clk) begin
      shreg_q <= shreg_d;
      if (reset) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         per_q      <= '0;
         adc_clk_q  <= 1'b0;
         adc_conv_q <= 1'b1;
         adc_ch_q   <= '0;
         we_q       <= 1'b0;
         wd_q       <= '0;
         wc_q       <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         per_q      <= per_d;
         adc_clk_q  <= adc_clk_d;
         adc_conv_q <= adc_conv_d;
         adc_ch_q   <= adc_ch_d;
         we_q       <= we_d;
         wd_q       <= wd_d;
         wc_q       <= wc_d;
      end
   end

   assign bus.adc_clk      = adc_clk_q;
   assign bus.adc_conv     = adc_conv_q;
   assign bus.adc_ch       = adc_ch_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.write_enable = we_q;
   assign bus.write_data   = wd_q;
   assign bus.write_ch     = wc_q;
endmodule
